snn_tm_network: RTL and testbench
=================================

# snn_tm_network

Time-multiplexed two-layer leaky integrate-and-fire network. It replaces the fully parallel two-layer datapath with a single synapse-accumulate/neuron-update engine that walks layer 1 and then layer 2, one synapse per cycle. Weight width and membrane width are parametrised, membrane arithmetic saturates, and each timestep runs under a start/busy/done handshake. It sits under the chip top as the network core, driven by the same spike/weight configuration registers.

## Interface
- M1, 8: input spikes to layer 1
- N1, 8: layer-1 neurons (= layer-2 fan-in)
- N2, 2: layer-2 neurons
- WB, 2: weight width, signed two's complement (WB ≥ 2)
- PW, 6: membrane/threshold/decay/refractory width; membrane signed
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  begin one timestep; accepted only when busy=0
- input_spikes  in  M1  captured on the accepted start cycle
- weights1  in  N1*M1*WB  weight of synapse (n,m) at bits [(n*M1+m)*WB +: WB]
- weights2  in  N2*N1*WB  same layout with M1→N1
- threshold1, decay1, refractory_period1  in  PW each  layer-1 parameters, unsigned
- threshold2, decay2, refractory_period2  in  PW each  layer-2 parameters, unsigned
- busy  out  1  timestep in progress
- done  out  1  one-cycle pulse at end of timestep
- output_spikes_layer1  out  N1  layer-1 spikes of the latest timestep
- output_spikes  out  N2  layer-2 spikes of the latest timestep
- membrane_potential_out  out  (N1+N2)*PW  neuron k at [k*PW +: PW]; layer 1 = k<N1

## Operation
- FSM: IDLE → L1_ACC ⇄ L1_UPD → L2_ACC ⇄ L2_UPD → DONE → IDLE.
- IDLE: on start=1, latch input_spikes, clear neuron index n and synapse index s, go to L1_ACC.
- xx_ACC: one synapse per cycle, acc += spike[s] ? sign-extended w(n,s) : 0. After s = fan-in−1, go to xx_UPD.
- xx_UPD, neuron n:
  - if ref_cnt[n] ≠ 0: ref_cnt−1, V=0, spike=0.
  - else sum = V + acc at full width. Leak toward zero: sum>decay → sum−decay; sum<−decay → sum+decay; otherwise 0.
  - if leaked ≥ zero-extended threshold: spike=1, V=0, ref_cnt=refractory_period.
  - otherwise V = leaked saturated to [−2^(PW−1), 2^(PW−1)−1], spike=0.
  - clear acc and s. If n is the last neuron of the layer, move to the next layer (n=0) or to DONE; otherwise n+1 and back to xx_ACC.
- acc width = PW+WB+clog2(max(M1,N1))+1; acc itself never overflows.
- Layer-1 spike vector commits in the last L1_UPD cycle. Layer 2 consumes this timestep's layer-1 spikes.
- output_spikes commits in the last L2_UPD cycle.
- Weights and threshold/decay/refractory inputs are read live and must be held stable while busy=1.
- refractory_period=0 means no refractory interval.
- Membrane and refractory state persist across timesteps. Only reset clears them.

## Timing
- Reset (reset=0 at a clock edge) → IDLE, busy=0, done=0, all spikes 0, all membranes 0, all ref_cnt 0, acc 0.
- Reset mid-timestep aborts it immediately: no done, all state cleared.
- Start accepted at edge 0. busy=1 from edge 1 until the DONE state is left.
- Layer 1 takes N1*(M1+1) cycles; layer 2 takes N2*(N1+1) cycles.
- done=1 for exactly one cycle, N1*(M1+1)+N2*(N1+1)+1 cycles after the start edge (91 at defaults). busy=0 in the cycle after done.
- start while busy=1 or done=1 is ignored (not queued).
- start in the cycle after done is accepted.
- membrane_potential_out is registered and updates in each neuron's UPD cycle.

## Test plan
- Fire-through, defaults. All weights1/weights2 = 2'b01, input_spikes=8'hFF, threshold 8, decay 0, refractory 0 → done at cycle 91; output_spikes_layer1=8'hFF; output_spikes=2'b11; all membranes 0.
- Negative saturation. weights1 = 2'b10 (−2), inputs 8'hFF, threshold1=31, decay1=0, three timesteps → layer-1 membranes −16, then −32, then −32 (6'b100000); no spikes.
- Leak. Only input bit 0 set, weights1=+1, decay1=1, threshold1=1 → membranes stay 0, no spikes over 4 timesteps.
- Refractory. Setup as fire-through with refractory_period1=2 → layer-1 spikes on timesteps 1 and 4 only; membranes 0 on timesteps 2–3.
- Handshake. start held high throughout → one timestep per 92 cycles; start pulses at cycles 10 and 50 are ignored (only the accepted start produces a done).
- Reset abort. reset=0 at cycle 40 of a timestep → busy=0 next cycle, no done, all outputs 0. A following start completes normally in 91 cycles.

Source files
------------

// File: rtl/snn_tm_network_if.sv
// Handshake and result bus of the time-multiplexed two-layer LIF network core.
// The controller side (chip top or bench) uses the master modport; the network core uses the slave modport.
interface snn_tm_network_if #(
    parameter int M1 = 8,
    parameter int N1 = 8,
    parameter int N2 = 2,
    parameter int PW = 6
);
    logic                     start;
    logic [M1-1:0]            input_spikes;
    logic                     busy;
    logic                     done;
    logic [N1-1:0]            output_spikes_layer1;
    logic [N2-1:0]            output_spikes;
    logic [(N1+N2)*PW-1:0]    membrane_potential_out;

    modport master (
        output start,
        output input_spikes,
        input  busy,
        input  done,
        input  output_spikes_layer1,
        input  output_spikes,
        input  membrane_potential_out
    );

    modport slave (
        input  start,
        input  input_spikes,
        output busy,
        output done,
        output output_spikes_layer1,
        output output_spikes,
        output membrane_potential_out
    );
endinterface

// File: rtl/snn_tm_network.sv
// Time-multiplexed two-layer leaky integrate-and-fire network core.
// A single accumulate/update engine walks layer 1 and then layer 2, one synapse per cycle.
// Membrane and refractory state persist across timesteps; only reset clears them.
module snn_tm_network #(
    parameter int M1 = 8,
    parameter int N1 = 8,
    parameter int N2 = 2,
    parameter int WB = 2,
    parameter int PW = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    snn_tm_network_if.slave       bus,
    input  logic [N1*M1*WB-1:0]   weights1,
    input  logic [N2*N1*WB-1:0]   weights2,
    input  logic [PW-1:0]         threshold1,
    input  logic [PW-1:0]         decay1,
    input  logic [PW-1:0]         refractory_period1,
    input  logic [PW-1:0]         threshold2,
    input  logic [PW-1:0]         decay2,
    input  logic [PW-1:0]         refractory_period2
);
    localparam int FI   = (M1 > N1) ? M1 : N1;
    localparam int NMAX = (N1 > N2) ? N1 : N2;
    localparam int AW   = PW + WB + $clog2(FI) + 1;
    localparam int SW   = AW + 1;
    localparam int IW   = $clog2(FI + 1);
    localparam int NW   = $clog2(NMAX + 1);
    localparam int NT   = N1 + N2;
    localparam int GW   = $clog2(NT);

    localparam logic signed [SW-1:0] V_MAX = {{(SW-PW+1){1'b0}}, {(PW-1){1'b1}}};
    localparam logic signed [SW-1:0] V_MIN = {{(SW-PW+1){1'b1}}, {(PW-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, L1_ACC, L1_UPD, L2_ACC, L2_UPD, DONE} state_t;

    state_t                 state, state_next;
    logic [NW-1:0]          n_idx;
    logic [IW-1:0]          s_idx;
    logic signed [AW-1:0]   acc;
    logic [M1-1:0]          in_spk;
    logic [N1-1:0]          l1_work, l1_out;
    logic [N2-1:0]          l2_work, l2_out;
    logic signed [PW-1:0]   v_mem   [NT];
    logic [PW-1:0]          ref_cnt [NT];

    logic                   is_l2, last_s, last_n, cur_spike, spk_upd;
    logic signed [WB-1:0]   cur_w;
    logic signed [AW-1:0]   w_ext, acc_sum;
    logic [GW-1:0]          gidx;
    logic [PW-1:0]          thr, dec, refp, ref_cur, ref_upd;
    logic signed [PW-1:0]   v_cur, v_upd;
    logic signed [SW-1:0]   sum, leaked, dec_s, thr_s;
    logic [N1-1:0]          l1_next;
    logic [N2-1:0]          l2_next;
    logic [NT*PW-1:0]       mem_flat;

    // Datapath: select the current synapse, accumulate it, and compute the neuron update for the current index
    always_comb begin
        is_l2     = (state == L2_ACC) || (state == L2_UPD);
        last_s    = is_l2 ? (s_idx == IW'(N1 - 1)) : (s_idx == IW'(M1 - 1));
        last_n    = is_l2 ? (n_idx == NW'(N2 - 1)) : (n_idx == NW'(N1 - 1));
        cur_spike = 1'b0;
        cur_w     = '0;
        if (state == L1_ACC) begin
            for (int i = 0; i < M1; i++)
                if (i == int'(s_idx)) cur_spike = in_spk[i];
            for (int i = 0; i < N1*M1; i++)
                if (i == int'(n_idx)*M1 + int'(s_idx)) cur_w = weights1[i*WB +: WB];
        end else if (state == L2_ACC) begin
            for (int i = 0; i < N1; i++)
                if (i == int'(s_idx)) cur_spike = l1_work[i];
            for (int i = 0; i < N2*N1; i++)
                if (i == int'(n_idx)*N1 + int'(s_idx)) cur_w = weights2[i*WB +: WB];
        end
        w_ext   = {{(AW-WB){cur_w[WB-1]}}, cur_w};
        acc_sum = acc + (cur_spike ? w_ext : '0);

        gidx    = is_l2 ? (GW'(N1) + GW'(n_idx)) : GW'(n_idx);
        thr     = is_l2 ? threshold2 : threshold1;
        dec     = is_l2 ? decay2 : decay1;
        refp    = is_l2 ? refractory_period2 : refractory_period1;
        v_cur   = v_mem[gidx];
        ref_cur = ref_cnt[gidx];
        dec_s   = {{(SW-PW){1'b0}}, dec};
        thr_s   = {{(SW-PW){1'b0}}, thr};
        sum     = {{(SW-PW){v_cur[PW-1]}}, v_cur} + {{(SW-AW){acc[AW-1]}}, acc};
        if (sum > dec_s)
            leaked = sum - dec_s;
        else if (sum < -dec_s)
            leaked = sum + dec_s;
        else
            leaked = '0;

        spk_upd = 1'b0;
        ref_upd = ref_cur;
        v_upd   = v_cur;
        if (ref_cur != '0) begin
            ref_upd = ref_cur - PW'(1);
            v_upd   = '0;
        end else if (leaked >= thr_s) begin
            spk_upd = 1'b1;
            v_upd   = '0;
            ref_upd = refp;
        end else if (leaked > V_MAX) begin
            v_upd   = V_MAX[PW-1:0];
        end else if (leaked < V_MIN) begin
            v_upd   = V_MIN[PW-1:0];
        end else begin
            v_upd   = leaked[PW-1:0];
        end

        l1_next = (l1_work & ~(N1'(1) << n_idx)) | (N1'(spk_upd) << n_idx);
        l2_next = (l2_work & ~(N2'(1) << n_idx)) | (N2'(spk_upd) << n_idx);
    end

    // Next-state logic: accumulate one synapse per cycle, then one update cycle per neuron, layer 1 before layer 2
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = L1_ACC;
            L1_ACC:  if (last_s) state_next = L1_UPD;
            L1_UPD:  state_next = last_n ? L2_ACC : L1_ACC;
            L2_ACC:  if (last_s) state_next = L2_UPD;
            L2_UPD:  state_next = last_n ? DONE : L2_ACC;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, indices, accumulator and per-neuron state; reset aborts any timestep in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            n_idx   <= '0;
            s_idx   <= '0;
            acc     <= '0;
            in_spk  <= '0;
            l1_work <= '0;
            l1_out  <= '0;
            l2_work <= '0;
            l2_out  <= '0;
            for (int k = 0; k < NT; k++) begin
                v_mem[k]   <= '0;
                ref_cnt[k] <= '0;
            end
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        in_spk <= bus.input_spikes;
                        n_idx  <= '0;
                        s_idx  <= '0;
                        acc    <= '0;
                    end
                end
                L1_ACC, L2_ACC: begin
                    acc   <= acc_sum;
                    s_idx <= s_idx + IW'(1);
                end
                L1_UPD, L2_UPD: begin
                    v_mem[gidx]   <= v_upd;
                    ref_cnt[gidx] <= ref_upd;
                    acc           <= '0;
                    s_idx         <= '0;
                    n_idx         <= last_n ? '0 : n_idx + NW'(1);
                    if (state == L1_UPD) begin
                        l1_work <= l1_next;
                        if (last_n) l1_out <= l1_next;
                    end else begin
                        l2_work <= l2_next;
                        if (last_n) l2_out <= l2_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // Flatten the membrane array onto the output bus, neuron k at slot k
    always_comb begin
        mem_flat = '0;
        for (int k = 0; k < NT; k++)
            mem_flat[k*PW +: PW] = v_mem[k];
    end

    assign bus.busy                   = (state != IDLE);
    assign bus.done                   = (state == DONE);
    assign bus.output_spikes_layer1   = l1_out;
    assign bus.output_spikes          = l2_out;
    assign bus.membrane_potential_out = mem_flat;
endmodule

// File: tb/tb_snn_tm_network.sv
// Directed bench for the time-multiplexed two-layer LIF network core.
module tb_snn_tm_network;
    localparam int M1 = 8;
    localparam int N1 = 8;
    localparam int N2 = 2;
    localparam int WB = 2;
    localparam int PW = 6;

    logic                  clk;
    logic                  reset;
    logic [N1*M1*WB-1:0]   weights1;
    logic [N2*N1*WB-1:0]   weights2;
    logic [PW-1:0]         threshold1, decay1, refractory_period1;
    logic [PW-1:0]         threshold2, decay2, refractory_period2;

    int vectors;
    int miscompares;

    snn_tm_network_if #(.M1(M1), .N1(N1), .N2(N2), .PW(PW)) bus ();

    snn_tm_network #(.M1(M1), .N1(N1), .N2(N2), .WB(WB), .PW(PW)) dut (
        .clk                (clk),
        .reset              (reset),
        .bus                (bus),
        .weights1           (weights1),
        .weights2           (weights2),
        .threshold1         (threshold1),
        .decay1             (decay1),
        .refractory_period1 (refractory_period1),
        .threshold2         (threshold2),
        .decay2             (decay2),
        .refractory_period2 (refractory_period2)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    // Pulse start for one cycle and return the index of the edge that samples done=1 (-1 on timeout).
    // Returns one cycle after done, where busy must already be low.
    task automatic applyStimulus(input logic [M1-1:0] spikes, output int lat);
        bus.input_spikes = spikes;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 300; c++) begin
            if (bus.done) begin
                lat = c;
                break;
            end
            tick();
        end
        tick();
    endtask

    function automatic logic [59:0] memPattern(input logic [5:0] l1v, input logic [5:0] l2v);
        logic [59:0] r;
        for (int k = 0; k < N1; k++) r[k*PW +: PW] = l1v;
        for (int k = N1; k < N1+N2; k++) r[k*PW +: PW] = l2v;
        return r;
    endfunction

    task automatic fireThroughConfig();
        weights1 = {(N1*M1){2'b01}};
        weights2 = {(N2*N1){2'b01}};
        threshold1 = 6'd8; decay1 = 6'd0; refractory_period1 = 6'd0;
        threshold2 = 6'd8; decay2 = 6'd0; refractory_period2 = 6'd0;
    endtask

    initial begin
        int lat;
        int d1, d2, dcount, dfirst;
        logic [59:0] pre;
        logic [M1-1:0] ff;
        vectors = 0;
        miscompares = 0;
        ff = '1;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.input_spikes = '0;
        fireThroughConfig();

        $display("[TB] reset state");
        resetDut();
        checkOutput("rst_busy", 64'(bus.busy), 64'd0);
        checkOutput("rst_done", 64'(bus.done), 64'd0);
        checkOutput("rst_l1", 64'(bus.output_spikes_layer1), 64'h0);
        checkOutput("rst_l2", 64'(bus.output_spikes), 64'h0);
        checkOutput("rst_mem", 64'(bus.membrane_potential_out), 64'h0);

        $display("[TB] fire-through");
        bus.input_spikes = ff;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checkOutput("ft_busy_after_start", 64'(bus.busy), 64'd1);
        resetDut();
        applyStimulus(ff, lat);
        checkOutput("ft_latency", 64'(lat), 64'd91);
        checkOutput("ft_busy_after_done", 64'(bus.busy), 64'd0);
        checkOutput("ft_l1", 64'(bus.output_spikes_layer1), 64'hFF);
        checkOutput("ft_l2", 64'(bus.output_spikes), 64'h3);
        checkOutput("ft_mem", 64'(bus.membrane_potential_out), 64'h0);

        $display("[TB] refractory");
        resetDut();
        refractory_period1 = 6'd2;
        for (int t = 1; t <= 4; t++) begin
            applyStimulus(ff, lat);
            checkOutput($sformatf("ref_lat_t%0d", t), 64'(lat), 64'd91);
            checkOutput($sformatf("ref_l1_t%0d", t), 64'(bus.output_spikes_layer1),
                        (t == 1 || t == 4) ? 64'hFF : 64'h0);
            checkOutput($sformatf("ref_l2_t%0d", t), 64'(bus.output_spikes),
                        (t == 1 || t == 4) ? 64'h3 : 64'h0);
            checkOutput($sformatf("ref_mem_t%0d", t), 64'(bus.membrane_potential_out), 64'h0);
        end

        $display("[TB] negative saturation");
        resetDut();
        fireThroughConfig();
        weights1 = {(N1*M1){2'b10}};
        threshold1 = 6'd31;
        for (int t = 1; t <= 3; t++) begin
            applyStimulus(ff, lat);
            checkOutput($sformatf("sat_l1_t%0d", t), 64'(bus.output_spikes_layer1), 64'h0);
            checkOutput($sformatf("sat_l2_t%0d", t), 64'(bus.output_spikes), 64'h0);
            checkOutput($sformatf("sat_mem_t%0d", t), 64'(bus.membrane_potential_out),
                        64'(memPattern((t == 1) ? 6'b110000 : 6'b100000, 6'd0)));
        end

        $display("[TB] leak");
        resetDut();
        fireThroughConfig();
        decay1 = 6'd1;
        threshold1 = 6'd1;
        for (int t = 1; t <= 4; t++) begin
            applyStimulus(8'h01, lat);
            checkOutput($sformatf("leak_l1_t%0d", t), 64'(bus.output_spikes_layer1), 64'h0);
            checkOutput($sformatf("leak_mem_t%0d", t), 64'(bus.membrane_potential_out), 64'h0);
        end

        $display("[TB] handshake, start held high");
        resetDut();
        fireThroughConfig();
        bus.input_spikes = ff;
        bus.start = 1'b1;
        d1 = -1;
        d2 = -1;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (bus.done) begin
                if (d1 < 0) d1 = c;
                else begin
                    d2 = c;
                    break;
                end
            end
        end
        bus.start = 1'b0;
        checkOutput("hs_first_done", 64'(d1), 64'd90);
        checkOutput("hs_period", 64'(d2 - d1), 64'd92);
        tick();
        tick();

        $display("[TB] handshake, start pulses while busy");
        bus.start = 1'b1;
        tick();
        dcount = 0;
        dfirst = -1;
        for (int c = 1; c <= 300; c++) begin
            bus.start = (c == 10 || c == 50);
            if (bus.done) begin
                dcount++;
                if (dfirst < 0) dfirst = c;
            end
            tick();
        end
        bus.start = 1'b0;
        checkOutput("hs_pulse_done_count", 64'(dcount), 64'd1);
        checkOutput("hs_pulse_done_cycle", 64'(dfirst), 64'd91);
        checkOutput("hs_pulse_idle", 64'(bus.busy), 64'd0);

        $display("[TB] reset abort");
        applyStimulus(ff, lat);
        weights1 = {(N1*M1){2'b10}};
        threshold1 = 6'd31;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (39) tick();
        pre = '0;
        for (int k = 0; k < 4; k++) pre[k*PW +: PW] = 6'b110000;
        checkOutput("abort_pre_mem", 64'(bus.membrane_potential_out), 64'(pre));
        checkOutput("abort_pre_l1", 64'(bus.output_spikes_layer1), 64'hFF);
        reset = 1'b0;
        tick();
        checkOutput("abort_busy", 64'(bus.busy), 64'd0);
        checkOutput("abort_done", 64'(bus.done), 64'd0);
        checkOutput("abort_l1", 64'(bus.output_spikes_layer1), 64'h0);
        checkOutput("abort_l2", 64'(bus.output_spikes), 64'h0);
        checkOutput("abort_mem", 64'(bus.membrane_potential_out), 64'h0);
        reset = 1'b1;
        dcount = 0;
        for (int c = 0; c < 120; c++) begin
            if (bus.done || bus.busy) dcount++;
            tick();
        end
        checkOutput("abort_no_done", 64'(dcount), 64'd0);
        fireThroughConfig();
        applyStimulus(ff, lat);
        checkOutput("abort_restart_latency", 64'(lat), 64'd91);
        checkOutput("abort_restart_l2", 64'(bus.output_spikes), 64'h3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
